mem_arbiter: RTL

//  Shares the single physical memory port between the instruction-side and data-side requesters
//  of the pipelined LC-3b. Each side uses the existing handshake: hold read/write, address, wdata
//  and byte enable stable until resp; rdata is valid in the resp cycle. Round-robin fairness on

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the LC-3b memory port arbiter
package mem_arbiter_pkg;

    localparam int LC3B_WORD_W = 16;
    localparam int LC3B_MASK_W = LC3B_WORD_W / 8;

    typedef logic [LC3B_WORD_W-1:0] lc3b_word;
    typedef logic [LC3B_MASK_W-1:0] lc3b_mem_wmask;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between I and D sides
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MASK_W-1:0] d_byte_enable,
    output logic              d_resp,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_byte_enable,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    grant_t     r_last_grant;
    logic       w_i_req;
    logic       w_d_req;
    logic       w_spurious_resp;
    logic       w_req_dropped;
    logic       w_rw_conflict;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GRANT_I;
        end else if (r_state == ARB_IDLE) begin
            if (w_next_state == ARB_SERVE_I) begin
                r_last_grant <= GRANT_I;
            end else if (w_next_state == ARB_SERVE_D) begin
                r_last_grant <= GRANT_D;
            end
        end
    end

    // On collision the side that did not win last time goes first.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_i_req && w_d_req) begin
                    w_next_state = (r_last_grant == GRANT_I) ? ARB_SERVE_D : ARB_SERVE_I;
                end else if (w_i_req) begin
                    w_next_state = ARB_SERVE_I;
                end else if (w_d_req) begin
                    w_next_state = ARB_SERVE_D;
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (mem_resp) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        i_resp          = 1'b0;
        d_resp          = 1'b0;
        case (r_state)
            ARB_SERVE_I: begin
                mem_read        = 1'b1;
                mem_address     = i_address;
                mem_byte_enable = '1;
                i_resp          = mem_resp;
            end
            ARB_SERVE_D: begin
                mem_read        = d_read;
                mem_write       = d_write;
                mem_address     = d_address;
                mem_wdata       = d_wdata;
                mem_byte_enable = d_byte_enable;
                d_resp          = mem_resp;
            end
            default: ;
        endcase
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // Protocol monitors: misbehaving requesters or memory are flagged, never corrected.
    assign w_spurious_resp = (r_state == ARB_IDLE) && mem_resp;
    assign w_req_dropped   = !mem_resp && (((r_state == ARB_SERVE_I) && !w_i_req) ||
                                           ((r_state == ARB_SERVE_D) && !w_d_req));
    assign w_rw_conflict   = d_read && d_write;

    a_no_req_drop:   assert property (@(posedge clk) disable iff (rst) !w_req_dropped);
    a_no_rw_overlap: assert property (@(posedge clk) disable iff (rst) !w_rw_conflict);
    c_spurious_resp: cover property (@(posedge clk) disable iff (rst) w_spurious_resp);

endmodule
